ni_param: RTL
=============

NI_PARAM -- requirements
Module: ni_param

Interface
REQ-001 Parameters: NODE_ID, default 0, this node's address.
REQ-002 Parameters: NUM_NODES, default 4, number of addressable nodes, range 2..2^ADDR_SZ.
REQ-003 Parameters: ADDR_SZ, default 4, destination field width in bits.
REQ-004 Parameters: PL_SZ, default 16, payload field width in bits.
REQ-005 Parameters: HDR_SZ, default 4, header field width in bits; HDR_SZ>=ADDR_SZ.
REQ-006 Parameters: TX_DEPTH, default 4, TX FIFO entries, power of two, >=2.
REQ-007 Parameters: RX_DEPTH, default 2, RX FIFO entries, power of two, >=2.
REQ-008 Parameters: DEST_MODE, default 1; 0=fixed FIXED_DEST, 1=round-robin skipping NODE_ID, 2=LFSR.
REQ-009 Parameters: FIXED_DEST, default 1, destination used in mode 0.
REQ-010 Ports: clk  in  1  single clock; all logic on rising edge.
REQ-011 Ports: reset  in  1  asynchronous, active-low reset.
REQ-012 Ports: send  in  1  one-cycle request to generate one flit.
REQ-013 Ports: item_out  out  W=HDR_SZ+PL_SZ+ADDR_SZ  flit to router.
REQ-014 Ports: req  out  1  item_out valid.
REQ-015 Ports: channel_busy  in  1  router back-pressure.
REQ-016 Ports: item_in  in  W  flit from router.
REQ-017 Ports: valid  in  1  item_in valid.
REQ-018 Ports: busy  out  1  back-pressure to router.
REQ-019 Ports: sink_stall  in  1  holds RX drain.
REQ-020 Ports: tx_count, rx_count, drop_count, err_count  out  16 each  statistics.

Function
REQ-021 Flit layout SHALL be: [W-1:PL_SZ+ADDR_SZ] = NODE_ID zero-extended; [PL_SZ+ADDR_SZ-1:ADDR_SZ] = sequence number; [ADDR_SZ-1:0] = destination.
REQ-022 On send, the block SHALL form a flit with the current sequence number and destination, then post-increment both (sequence wraps mod 2^PL_SZ).
REQ-023 Round-robin destination SHALL cycle 0..NUM_NODES-1, skip NODE_ID, and start at the first non-self node.
REQ-024 LFSR mode SHALL use a 16-bit maximal Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1), advanced per send; destination = LFSR mod NUM_NODES; a self result SHALL be replaced by (NODE_ID+1) mod NUM_NODES.
REQ-025 The flit SHALL be pushed to the TX FIFO; send while full with no same-cycle pop SHALL drop the flit, increment drop_count and still advance the sequence number.
REQ-026 TX FSM states: IDLE (req=0) and PRESENT (req=1, item_out = FIFO head).
REQ-027 IDLE->PRESENT SHALL occur on the edge after the FIFO becomes non-empty.
REQ-028 In PRESENT, a transfer SHALL occur at an edge where channel_busy=0: pop, tx_count++, then stay in PRESENT if the FIFO is still non-empty, else go to IDLE.
REQ-029 item_out SHALL remain stable while req=1 and channel_busy=1.
REQ-030 A push and a pop in the same cycle SHALL both succeed, including when the FIFO is full.
REQ-031 An RX accept SHALL occur when valid=1 and busy=0; the flit is written to the RX FIFO.
REQ-032 busy SHALL equal RX FIFO full, registered.
REQ-033 The RX FIFO SHALL drain one entry per cycle when sink_stall=0.
REQ-034 Each drained entry SHALL increment rx_count; a drained entry whose dest field != NODE_ID SHALL also increment err_count.
REQ-035 All counters SHALL saturate at 16'hFFFF.
REQ-036 Latency: send at edge N -> req=1 after edge N+1 if the FIFO was empty.

Reset
REQ-037 Reset low SHALL asynchronously force: req=0, busy=0, all counters=0, both FIFOs empty, FSM=IDLE, sequence=0, round-robin pointer to first non-self node, LFSR=16'hACE1.
REQ-038 Reset mid-transfer SHALL discard all queued flits; reset release SHALL be synchronised to clk.

Structure
REQ-039 Flit field offsets, DEST_MODE encodings and the LFSR seed SHALL live in the shared NoC constants package.
REQ-040 TX and RX FIFOs SHALL be two instances of one sub-module, ni_sync_fifo (parameters WIDTH, DEPTH; simultaneous push/pop at full allowed).

Verification
REQ-041 NODE_ID=0, NUM_NODES=4, mode 1, 4 sends, channel_busy=0 -> dests 1,2,3,1; seq 0..3; tx_count=4.
REQ-042 TX_DEPTH=4, channel_busy=1, 6 sends -> drop_count=2; after release, 4 flits with seq 0,1,2,3.
REQ-043 channel_busy toggled every cycle -> item_out stable while busy, no duplicated or lost seq.
REQ-044 sink_stall=1, 3 valid flits -> busy=1 after 2 accepts; third flit held until stall is released; rx_count=3.
REQ-045 Inject a flit with dest=2 at NODE_ID=0 -> err_count=1, rx_count=1.
REQ-046 Assert reset with 3 flits queued -> req=0 immediately; after release all counters=0, next flit seq=0.

Source files
------------

// File: rtl/ni_param_pkg.sv
// Shared NoC constants: flit field offsets, destination-mode encodings, the LFSR
// seed and its step function, and the TX FSM state type.
package ni_param_pkg;

  // Destination-selection modes
  localparam int unsigned DestFixed      = 0;
  localparam int unsigned DestRoundRobin = 1;
  localparam int unsigned DestLfsr       = 2;

  localparam logic [15:0] LfsrSeed = 16'hACE1;

  // Flit layout, LSB first: destination, sequence number, header (source node)
  localparam int unsigned DestLsb = 0;

  function automatic int unsigned seq_lsb(input int unsigned addr_sz);
    return addr_sz;
  endfunction

  function automatic int unsigned hdr_lsb(input int unsigned pl_sz, input int unsigned addr_sz);
    return pl_sz + addr_sz;
  endfunction

  // 16-bit maximal Fibonacci LFSR, taps 16,14,13,11
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c, input logic en);
    return (en && (c != 16'hFFFF)) ? c + 16'd1 : c;
  endfunction

  typedef enum logic {StIdle, StPresent} tx_state_e;

endpackage

// File: rtl/ni_sync_fifo.sv
// Synchronous FIFO; a push at full is accepted when a pop happens in the same cycle.
module ni_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == (AW + 1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Occupancy next-state
  always_comb begin
    cnt_d = cnt_q;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage; contents are don't-care while empty so no reset
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/ni_param.sv
// Network interface: generates sequenced flits toward the router through a TX FIFO
// and a present/transfer FSM, and sinks router flits through an RX FIFO with stats.
module ni_param
  import ni_param_pkg::*;
#(
  parameter int unsigned NODE_ID    = 0,
  parameter int unsigned NUM_NODES  = 4,
  parameter int unsigned ADDR_SZ    = 4,
  parameter int unsigned PL_SZ      = 16,
  parameter int unsigned HDR_SZ     = 4,
  parameter int unsigned TX_DEPTH   = 4,
  parameter int unsigned RX_DEPTH   = 2,
  parameter int unsigned DEST_MODE  = 1,
  parameter int unsigned FIXED_DEST = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             send,
  output logic [HDR_SZ+PL_SZ+ADDR_SZ-1:0] item_out,
  output logic                             req,
  input  logic                             channel_busy,
  input  logic [HDR_SZ+PL_SZ+ADDR_SZ-1:0] item_in,
  input  logic                             valid,
  output logic                             busy,
  input  logic                             sink_stall,
  output logic [15:0]                      tx_count,
  output logic [15:0]                      rx_count,
  output logic [15:0]                      drop_count,
  output logic [15:0]                      err_count
);

  localparam int unsigned W      = HDR_SZ + PL_SZ + ADDR_SZ;
  localparam int unsigned SeqLsb = seq_lsb(ADDR_SZ);
  localparam int unsigned HdrLsb = hdr_lsb(PL_SZ, ADDR_SZ);
  localparam int unsigned TxCntW = $clog2(TX_DEPTH) + 1;
  localparam int unsigned RxCntW = $clog2(RX_DEPTH) + 1;
  localparam logic [ADDR_SZ-1:0] SelfAddr = ADDR_SZ'(NODE_ID);
  localparam logic [ADDR_SZ-1:0] SelfAlt  = ADDR_SZ'((NODE_ID + 1) % NUM_NODES);
  localparam logic [ADDR_SZ-1:0] RrFirst  = (NODE_ID == 0) ? ADDR_SZ'(1) : '0;

  logic [1:0]         rst_sync_q;
  logic               rst_n;
  logic [PL_SZ-1:0]   seq_q;
  logic [ADDR_SZ-1:0] rr_q, rr_next, lfsr_dest, dest_cur;
  logic [15:0]        lfsr_q;
  logic [W-1:0]       tx_flit, tx_rdata, rx_rdata;
  logic               tx_full, tx_empty, tx_pop, drop;
  logic               rx_full, rx_empty, rx_push, rx_pop, rx_err;
  logic [TxCntW-1:0]  tx_cnt;
  logic [RxCntW-1:0]  rx_cnt, rx_cnt_nxt;
  logic               busy_q, busy_d;
  logic [15:0]        tx_count_q, rx_count_q, drop_count_q, err_count_q;
  logic               rx_unused;
  tx_state_e          state_q, state_d;

  // Reset asserts asynchronously, releases two edges after reset rises
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync_q <= '0;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  function automatic logic [ADDR_SZ-1:0] rr_inc(input logic [ADDR_SZ-1:0] a);
    if (32'(a) + 32'd1 >= NUM_NODES) return '0;
    return a + 1'b1;
  endfunction

  // Destination for the current send and the next round-robin pointer
  always_comb begin
    rr_next = rr_inc(rr_q);
    if (rr_next == SelfAddr) rr_next = rr_inc(rr_next);
    lfsr_dest = ADDR_SZ'(32'(lfsr_q) % NUM_NODES);
    if (lfsr_dest == SelfAddr) lfsr_dest = SelfAlt;
    if (DEST_MODE == DestFixed)     dest_cur = ADDR_SZ'(FIXED_DEST);
    else if (DEST_MODE == DestLfsr) dest_cur = lfsr_dest;
    else                            dest_cur = rr_q;
  end

  // Flit assembly
  always_comb begin
    tx_flit                       = '0;
    tx_flit[HdrLsb +: HDR_SZ]     = HDR_SZ'(NODE_ID);
    tx_flit[SeqLsb +: PL_SZ]      = seq_q;
    tx_flit[DestLsb +: ADDR_SZ]   = dest_cur;
  end

  // Sequence and destination generators advance on every send, dropped or not
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_q  <= '0;
      rr_q   <= RrFirst;
      lfsr_q <= LfsrSeed;
    end else if (send) begin
      seq_q  <= seq_q + 1'b1;
      rr_q   <= rr_next;
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  assign tx_pop = (state_q == StPresent) && !channel_busy;
  assign drop   = send && tx_full && !tx_pop;

  ni_sync_fifo #(.WIDTH(W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (send),
    .wdata_i (tx_flit),
    .pop_i   (tx_pop),
    .rdata_o (tx_rdata),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_cnt)
  );

  // TX FSM next state; leaves PRESENT only when the last entry goes with no refill
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (!tx_empty) state_d = StPresent;
      StPresent: if (tx_pop && (tx_cnt == TxCntW'(1)) && !send) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // TX FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  assign req      = (state_q == StPresent);
  assign item_out = tx_rdata;

  assign rx_push = valid && !busy_q;
  assign rx_pop  = !rx_empty && !sink_stall;
  assign rx_err  = rx_pop && (rx_rdata[DestLsb +: ADDR_SZ] != SelfAddr);
  assign rx_unused = ^{rx_rdata[HdrLsb +: HDR_SZ], rx_rdata[SeqLsb +: PL_SZ], rx_full};

  ni_sync_fifo #(.WIDTH(W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (rx_push),
    .wdata_i (item_in),
    .pop_i   (rx_pop),
    .rdata_o (rx_rdata),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .count_o (rx_cnt)
  );

  // busy is registered from next-cycle occupancy so it always equals RX full
  always_comb begin
    rx_cnt_nxt = rx_cnt;
    if (rx_push) rx_cnt_nxt = rx_cnt_nxt + 1'b1;
    if (rx_pop)  rx_cnt_nxt = rx_cnt_nxt - 1'b1;
    busy_d = (rx_cnt_nxt == RxCntW'(RX_DEPTH));
  end

  // Back-pressure flag and saturating statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q       <= 1'b0;
      tx_count_q   <= '0;
      rx_count_q   <= '0;
      drop_count_q <= '0;
      err_count_q  <= '0;
    end else begin
      busy_q       <= busy_d;
      tx_count_q   <= sat_inc(tx_count_q, tx_pop);
      rx_count_q   <= sat_inc(rx_count_q, rx_pop);
      drop_count_q <= sat_inc(drop_count_q, drop);
      err_count_q  <= sat_inc(err_count_q, rx_err);
    end
  end

  assign busy       = busy_q;
  assign tx_count   = tx_count_q;
  assign rx_count   = rx_count_q;
  assign drop_count = drop_count_q;
  assign err_count  = err_count_q;

endmodule
